adc_spi_capture: RTL
====================

Name: adc_spi_capture

Overview:
SPI master for one LTC2315-12 serial ADC channel. It generates CS/SCK, shifts in SDO, and emits 16-bit zero-extended samples with a one-cycle valid strobe.
It sits directly upstream of the fifo_acp write port, replacing the adc_imi imitator in the top level. One instance is used per ADC channel; both instances share the same `start` enable.

Parameters:
CLK_DIV, 2, clk cycles per SCK half-period (SCK = clk/(2*CLK_DIV)); must be ≥1
FRAME_BITS, 16, SCK cycles per CS-low frame
LEAD_BITS, 1, leading zero bits preceding the data MSB
DATA_BITS, 12, conversion result width
SAMPLE_PERIOD, 100, clk cycles between successive CS falling edges

Ports:
clk  in  1  system clock (clk_dv domain, 50 MHz)
rst_n  in  1  asynchronous active-low reset
start  in  1  level enable; conversions run while high
sdo  in  1  ADC serial data (already IBUF'd)
sck  out  1  serial clock to ADC
cs  out  1  ADC chip select / convert, active low
adc_data  out  16  {(16-DATA_BITS)'b0, result}
adc_en  out  1  one-cycle strobe, adc_data valid
frame_err  out  1  one-cycle, coincident with adc_en: a leading bit was nonzero
busy  out  1  high from CS fall through the adc_en cycle
missed_cnt  out  8  saturating count of sample ticks lost while busy

Behaviour:
- Reset (async, rst_n=0): cs=1, sck=0, adc_data=0, adc_en=0, frame_err=0, busy=0, missed_cnt=0, period counter=0, state=IDLE.
  - Reset applied mid-frame forces these values immediately.
- Period counter:
  - counts 0..SAMPLE_PERIOD-1 while start=1 and wraps.
  - held at 0 while start=0.
  - A tick is produced when the count equals 0 with start=1, so the first frame starts on the first clk edge after start rises.
- FSM states:
  - IDLE: on tick → SETUP. cs goes low at this edge; busy=1.
  - SETUP: lasts CLK_DIV cycles with sck=0 → SHIFT.
  - SHIFT: FRAME_BITS SCK periods. Each period is CLK_DIV cycles low, then CLK_DIV cycles high.
    - sdo is captured into the MSB-first shift register at the same clk edge that drives sck 0→1.
    - After the high half of the last bit: sck=0, cs=1 → DONE.
  - DONE: one cycle.
    - adc_en=1.
    - adc_data = shift[FRAME_BITS-1-LEAD_BITS -: DATA_BITS], zero-extended.
    - frame_err = |shift[FRAME_BITS-1 -: LEAD_BITS].
    - busy=0 → IDLE.
- Frame latency:
  - Frame length from CS fall to adc_en is CLK_DIV*(2*FRAME_BITS+1)+1 cycles; 67 with the defaults.
  - Minimum legal SAMPLE_PERIOD is that value + 1 (guaranteed CS-high ≥1 cycle).
- Missed tick: a tick arriving while busy or in DONE is dropped. missed_cnt increments and saturates at 255; the frame in progress is unaffected.
- start falling mid-frame: the current frame completes normally, including adc_en. No further frames start.
- adc_data holds its value until the next DONE. adc_en is never asserted outside DONE.
- sck idles low; cs idles high.

Optional Feature:
ADC_TEST_RAMP_EN
- Defined: sdo is ignored and the shift register is loaded from an internal 12-bit ramp that increments once per frame.
  - The ramp wraps 0xFFF→0x000.
  - The ramp value is placed after the LEAD_BITS zeros.
  - All CS/SCK timing is unchanged, so lab bring-up needs no ADC fitted.
  - frame_err is always 0.
- Undefined: normal sdo capture; no ramp logic is synthesised.

Decomposition:
- Shared package mbo53_adc_pkg holds:
  - FSM state encoding (IDLE, SETUP, SHIFT, DONE)
  - LTC2315 frame constants (FRAME_BITS=16, LEAD_BITS=1, DATA_BITS=12)
  - ADC_OUT_W=16, matching the fifo_acp din width
- One natural sub-module: adc_sck_gen. It holds the half-period divider and the bit counter, and outputs sck, a rise strobe and a last-bit flag. The FSM, capture and period logic stay in adc_spi_capture.

Test Plan:
- Reset: hold rst_n=0 with start=1 → cs=1, sck=0, adc_en=0, missed_cnt=0 throughout. Assert rst_n=0 mid-SHIFT → cs=1, sck=0 with no clk edge needed.
- Single frame:
  - Stimulus: sdo model drives 0,0xABC,000 MSB-first, changing on sck fall; defaults.
  - Required response: adc_en exactly 67 cycles after cs falls, adc_data=16'h0ABC, frame_err=0, exactly 16 sck rising edges per frame.
- Continuous run: start=1 for 350 cycles → CS falls at cycles 0, 100, 200 and 300; 4 adc_en pulses; missed_cnt=0.
- start dropped at cycle 30 of a frame → the frame completes with adc_en and correct data; cs stays high afterward.
- Overrun: SAMPLE_PERIOD=40, start=1 for 400 cycles → each tick while busy is dropped and counted; missed_cnt=5, and adc_en pulses=5, one per frame at its 67-cycle completion.
- Error and ramp:
  - sdo leading bit=1 → frame_err=1 coincident with adc_en.
  - With ADC_TEST_RAMP_EN: successive adc_data = 0x0000, 0x0001, 0x0002…, wrapping to 0x0000 after 0x0FFF.

Source files
------------

// File: rtl/mbo53_adc_pkg.sv
// Shared definitions for the LTC2315-12 capture path: FSM encoding,
// serial frame layout of the converter and the downstream FIFO word width.
package mbo53_adc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } adc_state_t;

    // LTC2315-12 frame: one leading zero, 12 result bits, trailing zeros
    localparam int LTC_FRAME_BITS = 16;
    localparam int LTC_LEAD_BITS  = 1;
    localparam int LTC_DATA_BITS  = 12;

    // Matches the fifo_acp write data width
    localparam int ADC_OUT_W = 16;

    // Places a result value where the ADC would put it inside a frame:
    // behind the leading zeros, followed by trailing zeros.
    function automatic logic [LTC_FRAME_BITS-1:0] frame_word(
        input logic [LTC_DATA_BITS-1:0] value
    );
        return LTC_FRAME_BITS'(value) << (LTC_FRAME_BITS - LTC_LEAD_BITS - LTC_DATA_BITS);
    endfunction

endpackage

// File: rtl/adc_sck_gen.sv
// SCK generator: half-period divider plus bit counter.
// The divider runs through SETUP and SHIFT so the FSM can time the CS-to-first
// SCK setup with the same half-period strobe; sck only toggles during SHIFT.
module adc_sck_gen #(
    parameter int CLK_DIV    = 2,
    parameter int FRAME_BITS = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,       // SETUP or SHIFT: divider counting
    input  logic shifting,  // SHIFT: sck toggling, bits counted
    output logic sck,
    output logic half_end,  // last clk of the current half period
    output logic rise,      // this edge drives sck 0->1
    output logic last_bit   // bit counter is on the final bit of the frame
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(FRAME_BITS + 1);

    logic [DW-1:0] div_cnt;
    logic [BW-1:0] bit_cnt;

    assign half_end = run && (div_cnt == DW'(CLK_DIV - 1));
    assign rise     = shifting && half_end && !sck;
    assign last_bit = (bit_cnt == BW'(FRAME_BITS - 1));

    // Half-period divider, parked at zero outside a frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (!run || half_end) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // SCK toggle and bit count; a bit ends on the high->low transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck     <= 1'b0;
            bit_cnt <= '0;
        end else if (!shifting) begin
            sck     <= 1'b0;
            bit_cnt <= '0;
        end else if (half_end) begin
            sck <= ~sck;
            if (sck) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_spi_capture.sv
// SPI master for one LTC2315-12 channel feeding the fifo_acp write port.
// Optional build macro ADC_TEST_RAMP_EN: replaces sdo with an internal ramp
// (one step per frame) so CS/SCK timing can be exercised without an ADC.
// LEAD_BITS must be at least 1; SAMPLE_PERIOD must exceed the frame length
// CLK_DIV*(2*FRAME_BITS+1)+1 so CS stays high for at least one cycle.
module adc_spi_capture
    import mbo53_adc_pkg::*;
#(
    parameter int CLK_DIV       = 2,
    parameter int FRAME_BITS    = LTC_FRAME_BITS,
    parameter int LEAD_BITS     = LTC_LEAD_BITS,
    parameter int DATA_BITS     = LTC_DATA_BITS,
    parameter int SAMPLE_PERIOD = 100
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 sdo,
    output logic                 sck,
    output logic                 cs,
    output logic [ADC_OUT_W-1:0] adc_data,
    output logic                 adc_en,
    output logic                 frame_err,
    output logic                 busy,
    output logic [7:0]           missed_cnt
);
    localparam int PW = $clog2(SAMPLE_PERIOD);

    adc_state_t             state;
    logic [PW-1:0]          per_cnt;
    logic                   tick;
    logic [FRAME_BITS-1:0]  shift_reg;
    logic                   serial_in;
    logic                   half_end;
    logic                   rise;
    logic                   last_bit;
    logic                   run;
    logic                   shifting;

    assign run      = (state == ST_SETUP) || (state == ST_SHIFT);
    assign shifting = (state == ST_SHIFT);
    assign tick     = start && (per_cnt == '0);

    adc_sck_gen #(
        .CLK_DIV    (CLK_DIV),
        .FRAME_BITS (FRAME_BITS)
    ) u_sck_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .shifting (shifting),
        .sck      (sck),
        .half_end (half_end),
        .rise     (rise),
        .last_bit (last_bit)
    );

    // Sample period counter: free-runs while enabled, parked at 0 otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt <= '0;
        end else if (!start) begin
            per_cnt <= '0;
        end else if (per_cnt == PW'(SAMPLE_PERIOD - 1)) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + 1'b1;
        end
    end

`ifdef ADC_TEST_RAMP_EN
    logic [DATA_BITS-1:0]  ramp;
    logic [FRAME_BITS-1:0] ramp_sr;

    // Ramp source: a frame image loaded at CS fall and shifted out on each SCK rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ramp    <= '0;
            ramp_sr <= '0;
        end else begin
            if (state == ST_IDLE && tick) begin
                ramp_sr <= FRAME_BITS'(ramp) << (FRAME_BITS - LEAD_BITS - DATA_BITS);
            end else if (rise) begin
                ramp_sr <= ramp_sr << 1;
            end
            if (state == ST_DONE) begin
                ramp <= ramp + 1'b1;
            end
        end
    end

    assign serial_in = ramp_sr[FRAME_BITS-1];
`else
    assign serial_in = sdo;
`endif

    // MSB-first capture on the same edge that raises SCK
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
        end else if (rise) begin
            shift_reg <= {shift_reg[FRAME_BITS-2:0], serial_in};
        end
    end

    // Frame FSM with registered CS, busy and result outputs.
    // A tick is only accepted in IDLE; busy stays high through the adc_en
    // cycle, which is already IDLE so a minimum-period tick is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cs        <= 1'b1;
            busy      <= 1'b0;
            adc_en    <= 1'b0;
            adc_data  <= '0;
            frame_err <= 1'b0;
        end else begin
            adc_en    <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    busy <= tick;
                    if (tick) begin
                        state <= ST_SETUP;
                        cs    <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    if (half_end) begin
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (half_end && sck && last_bit) begin
                        state <= ST_DONE;
                        cs    <= 1'b1;
                    end
                end
                ST_DONE: begin
                    adc_en   <= 1'b1;
                    adc_data <= ADC_OUT_W'(shift_reg[FRAME_BITS-1-LEAD_BITS -: DATA_BITS]);
`ifdef ADC_TEST_RAMP_EN
                    frame_err <= 1'b0;
`else
                    frame_err <= |shift_reg[FRAME_BITS-1 -: LEAD_BITS];
`endif
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    cs    <= 1'b1;
                end
            endcase
        end
    end

    // Ticks that land mid-frame are dropped and counted, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            missed_cnt <= '0;
        end else if (tick && state != ST_IDLE && missed_cnt != 8'hFF) begin
            missed_cnt <= missed_cnt + 1'b1;
        end
    end

endmodule
